// File: rtl/lcd_responder_pkg.sv
// ============================================================================
// Module   : lcd_responder_pkg
// Brief    : Shared opcodes, DDRAM geometry and address-counter helpers for
//            the HD44780-compatible responder.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package lcd_responder_pkg;

    localparam logic [7:0] c_op_set_ddram   = 8'h80;
    localparam logic [7:0] c_mask_set_ddram = 8'h80;
    localparam logic [7:0] c_op_set_cgram   = 8'h40;
    localparam logic [7:0] c_mask_set_cgram = 8'hC0;
    localparam logic [7:0] c_op_func_set    = 8'h20;
    localparam logic [7:0] c_mask_func_set  = 8'hE0;
    localparam logic [7:0] c_op_shift       = 8'h10;
    localparam logic [7:0] c_mask_shift     = 8'hF0;
    localparam logic [7:0] c_op_display     = 8'h08;
    localparam logic [7:0] c_mask_display   = 8'hF8;
    localparam logic [7:0] c_op_entry       = 8'h04;
    localparam logic [7:0] c_mask_entry     = 8'hFC;
    localparam logic [7:0] c_op_home        = 8'h02;
    localparam logic [7:0] c_mask_home      = 8'hFE;
    localparam logic [7:0] c_op_clear       = 8'h01;
    localparam logic [7:0] c_mask_clear     = 8'hFF;

    localparam logic [6:0] c_line0_base   = 7'h00;
    localparam logic [6:0] c_line1_base   = 7'h40;
    localparam logic [6:0] c_line_len     = 7'd16;
    // Each DDRAM line spans 40 addresses, of which only the first 16 are shown.
    localparam logic [6:0] c_line_span    = 7'd40;
    localparam logic [7:0] c_blank_char   = 8'h20;
    localparam int         c_ddram_depth  = 32;

    typedef enum logic [1:0] {
        ST_READY = 2'd0,
        ST_CLEAR = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
        logic [6:0] r;
        if (inc) begin
            if (a == c_line0_base + c_line_span - 7'd1)      r = c_line1_base;
            else if (a == c_line1_base + c_line_span - 7'd1) r = c_line0_base;
            else                                             r = a + 7'd1;
        end else begin
            if (a == c_line1_base)      r = c_line0_base + c_line_span - 7'd1;
            else if (a == c_line0_base) r = c_line1_base + c_line_span - 7'd1;
            else                        r = a - 7'd1;
        end
        return r;
    endfunction

    function automatic logic ac_visible(input logic [6:0] a);
        return ((a - c_line0_base) < c_line_len) || ((a - c_line1_base) < c_line_len);
    endfunction

    function automatic logic [4:0] ac_index(input logic [6:0] a);
        return {a[6], a[3:0]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_responder_sync.sv
// ============================================================================
// Module   : lcd_responder_sync
// Brief    : Multi-stage flop synchronizer for the asynchronous LCD bus pins.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lcd_responder_sync #(
    parameter int WIDTH  = 7,
    parameter int STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [STAGES-1:0][WIDTH-1:0] stage_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[STAGES-2:0], din};
        end
    end

    assign dout = stage_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/lcd_responder.sv
// ============================================================================
// Module   : lcd_responder
// Brief    : Device end of an HD44780-style RS/RW/EN/DATA[3:0] bus with a
//            2x16 DDRAM mirror, busy-flag timing and bus read-back.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lcd_responder
    import lcd_responder_pkg::*;
#(
    parameter int CLK_MHZ      = 240,
    parameter int CNT_WIDTH    = 19,
    parameter int EXEC_CYCLES  = 37 * CLK_MHZ,
    parameter int CLEAR_CYCLES = 1520 * CLK_MHZ
) (
    input  logic       CLK,
    input  logic       RST,
    inout  wire  [3:0] LCD_DATA,
    input  logic       RS,
    input  logic       RW,
    input  logic       EN,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char,
    output logic [6:0] ac,
    output logic       busy_flag,
    output logic       display_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       four_bit,
    output logic       two_line,
    output logic       proto_err
);

    // Counters count down to zero inclusive; clear spends 32 of its cycles wiping DDRAM.
    localparam logic [CNT_WIDTH-1:0] c_exec_load  = CNT_WIDTH'(EXEC_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] c_home_load  = CNT_WIDTH'(CLEAR_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] c_clear_load = CNT_WIDTH'(CLEAR_CYCLES - 1 - c_ddram_depth);

    logic       rs_s, rw_s, en_s;
    logic [3:0] dat_s;

    lcd_responder_sync #(.WIDTH(7), .STAGES(2)) u_sync (
        .CLK  (CLK),
        .RST  (RST),
        .din  ({RS, RW, EN, LCD_DATA}),
        .dout ({rs_s, rw_s, en_s, dat_s})
    );

    state_t                state_q,      state_d;
    logic [CNT_WIDTH-1:0]  busy_cnt_q,   busy_cnt_d;
    logic [4:0]            clr_idx_q,    clr_idx_d;
    logic [6:0]            ac_q,         ac_d;
    logic                  id_q,         id_d;
    logic                  display_q,    display_d;
    logic                  cursor_q,     cursor_d;
    logic                  blink_q,      blink_d;
    logic                  four_bit_q,   four_bit_d;
    logic                  two_line_q,   two_line_d;
    logic                  proto_err_q,  proto_err_d;
    logic                  busy_flag_q,  busy_flag_d;
    logic                  nib_hi_q,     nib_hi_d;
    logic [3:0]            hi_nib_q,     hi_nib_d;
    logic                  en_prev_q;
    logic [7:0]            rd_char_q,    rd_char_d;
    logic [7:0]            ddram_q [c_ddram_depth];

    logic       en_fall;
    logic       wr_done;
    logic [7:0] wr_byte;
    logic       go_exec;
    logic       ddram_we;
    logic [4:0] ddram_wa;
    logic [7:0] ddram_wd;
    logic [7:0] bus_char;
    logic [3:0] rd_nib;
    logic       rd_oe;

    assign en_fall = en_prev_q & ~en_s;
    assign rd_oe   = en_s & rw_s;

    always_comb begin
        state_d     = state_q;
        busy_cnt_d  = busy_cnt_q;
        clr_idx_d   = clr_idx_q;
        ac_d        = ac_q;
        id_d        = id_q;
        display_d   = display_q;
        cursor_d    = cursor_q;
        blink_d     = blink_q;
        four_bit_d  = four_bit_q;
        two_line_d  = two_line_q;
        proto_err_d = proto_err_q;
        nib_hi_d    = nib_hi_q;
        hi_nib_d    = hi_nib_q;
        wr_done     = 1'b0;
        wr_byte     = 8'h00;
        go_exec     = 1'b0;
        ddram_we    = 1'b0;
        ddram_wa    = 5'd0;
        ddram_wd    = c_blank_char;

        if (en_fall) begin
            if (four_bit_q) begin
                nib_hi_d = ~nib_hi_q;
            end
            if (rw_s) begin
                if (rs_s && (!four_bit_q || !nib_hi_q)) begin
                    ac_d = ac_step(ac_q, id_q);
                end
            end else if (!four_bit_q) begin
                wr_done = 1'b1;
                wr_byte = {dat_s, 4'b0000};
            end else if (nib_hi_q) begin
                hi_nib_d = dat_s;
            end else begin
                wr_done = 1'b1;
                wr_byte = {hi_nib_q, dat_s};
            end
        end

        case (state_q)
            ST_READY: begin
                if (wr_done) begin
                    if (rs_s) begin
                        // Data writes only exist once the 4-bit interface is up.
                        if (four_bit_q) begin
                            if (ac_visible(ac_q)) begin
                                ddram_we = 1'b1;
                                ddram_wa = ac_index(ac_q);
                                ddram_wd = wr_byte;
                            end
                            ac_d    = ac_step(ac_q, id_q);
                            go_exec = 1'b1;
                        end
                    end else if ((wr_byte & c_mask_func_set) == c_op_func_set) begin
                        four_bit_d = ~wr_byte[4];
                        two_line_d = wr_byte[3];
                        go_exec    = 1'b1;
                    end else if (four_bit_q) begin
                        if ((wr_byte & c_mask_set_ddram) == c_op_set_ddram) begin
                            ac_d    = wr_byte[6:0];
                            go_exec = 1'b1;
                        end else if ((wr_byte & c_mask_set_cgram) == c_op_set_cgram) begin
                            go_exec = 1'b0;
                        end else if ((wr_byte & c_mask_shift) == c_op_shift) begin
                            if (!wr_byte[3]) begin
                                ac_d = ac_step(ac_q, wr_byte[2]);
                            end
                            go_exec = 1'b1;
                        end else if ((wr_byte & c_mask_display) == c_op_display) begin
                            display_d = wr_byte[2];
                            cursor_d  = wr_byte[1];
                            blink_d   = wr_byte[0];
                            go_exec   = 1'b1;
                        end else if ((wr_byte & c_mask_entry) == c_op_entry) begin
                            id_d    = wr_byte[1];
                            go_exec = 1'b1;
                        end else if ((wr_byte & c_mask_home) == c_op_home) begin
                            ac_d       = 7'h00;
                            state_d    = ST_BUSY;
                            busy_cnt_d = c_home_load;
                        end else if ((wr_byte & c_mask_clear) == c_op_clear) begin
                            ac_d       = 7'h00;
                            id_d       = 1'b1;
                            clr_idx_d  = 5'd0;
                            state_d    = ST_CLEAR;
                            busy_cnt_d = c_clear_load;
                        end
                    end
                end
                if (go_exec) begin
                    state_d    = ST_BUSY;
                    busy_cnt_d = c_exec_load;
                end
            end
            ST_CLEAR: begin
                ddram_we  = 1'b1;
                ddram_wa  = clr_idx_q;
                ddram_wd  = c_blank_char;
                clr_idx_d = clr_idx_q + 5'd1;
                ac_d      = 7'h00;
                id_d      = 1'b1;
                if (clr_idx_q == 5'(c_ddram_depth - 1)) begin
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (busy_cnt_q == '0) begin
                    state_d = ST_READY;
                end else begin
                    busy_cnt_d = busy_cnt_q - CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = ST_READY;
            end
        endcase

        if (wr_done && busy_flag_q) begin
            proto_err_d = 1'b1;
        end

        busy_flag_d = (state_d != ST_READY);
        rd_char_d   = ddram_q[rd_addr];
    end

    always_comb begin
        bus_char = ac_visible(ac_q) ? ddram_q[ac_index(ac_q)] : c_blank_char;
        if (!rs_s) begin
            rd_nib = nib_hi_q ? {busy_flag_q, ac_q[6:4]} : ac_q[3:0];
        end else begin
            rd_nib = nib_hi_q ? bus_char[7:4] : bus_char[3:0];
        end
    end

    assign LCD_DATA = rd_oe ? rd_nib : 4'bzzzz;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_READY;
            busy_cnt_q  <= '0;
            clr_idx_q   <= 5'd0;
            ac_q        <= 7'h00;
            id_q        <= 1'b1;
            display_q   <= 1'b0;
            cursor_q    <= 1'b0;
            blink_q     <= 1'b0;
            four_bit_q  <= 1'b0;
            two_line_q  <= 1'b0;
            proto_err_q <= 1'b0;
            busy_flag_q <= 1'b0;
            nib_hi_q    <= 1'b1;
            hi_nib_q    <= 4'h0;
            en_prev_q   <= 1'b0;
            rd_char_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            busy_cnt_q  <= busy_cnt_d;
            clr_idx_q   <= clr_idx_d;
            ac_q        <= ac_d;
            id_q        <= id_d;
            display_q   <= display_d;
            cursor_q    <= cursor_d;
            blink_q     <= blink_d;
            four_bit_q  <= four_bit_d;
            two_line_q  <= two_line_d;
            proto_err_q <= proto_err_d;
            busy_flag_q <= busy_flag_d;
            nib_hi_q    <= nib_hi_d;
            hi_nib_q    <= hi_nib_d;
            en_prev_q   <= en_s;
            rd_char_q   <= rd_char_d;
        end
    end

    // Host read samples the pre-write contents when both touch the same cell.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < c_ddram_depth; i++) begin
                ddram_q[i] <= c_blank_char;
            end
        end else if (ddram_we) begin
            ddram_q[ddram_wa] <= ddram_wd;
        end
    end

    assign rd_char    = rd_char_q;
    assign ac         = ac_q;
    assign busy_flag  = busy_flag_q;
    assign display_on = display_q;
    assign cursor_on  = cursor_q;
    assign blink_on   = blink_q;
    assign four_bit   = four_bit_q;
    assign two_line   = two_line_q;
    assign proto_err  = proto_err_q;

endmodule

`default_nettype wire

// File: tb/tb_lcd_responder.sv
// ============================================================================
// Module   : tb_lcd_responder
// Brief    : Directed self-checking bench for lcd_responder (1 MHz timing).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lcd_responder;

    localparam int c_exec  = 37;
    localparam int c_clear = 1520;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rs = 1'b0, rw = 1'b0, en = 1'b0;
    logic       tb_oe = 1'b1;
    logic [3:0] tb_dq = 4'h0;
    wire  [3:0] lcd_data;
    logic [4:0] rd_addr = 5'd0;
    logic [7:0] rd_char;
    logic [6:0] ac;
    logic       busy_flag, display_on, cursor_on, blink_on, four_bit, two_line, proto_err;

    int checks = 0;
    int failures = 0;
    int bf_run = 0;
    int last_bf_len = 0;

    assign lcd_data = tb_oe ? tb_dq : 4'bzzzz;

    lcd_responder #(.CLK_MHZ(1)) dut (
        .CLK        (clk),
        .RST        (rst_n),
        .LCD_DATA   (lcd_data),
        .RS         (rs),
        .RW         (rw),
        .EN         (en),
        .rd_addr    (rd_addr),
        .rd_char    (rd_char),
        .ac         (ac),
        .busy_flag  (busy_flag),
        .display_on (display_on),
        .cursor_on  (cursor_on),
        .blink_on   (blink_on),
        .four_bit   (four_bit),
        .two_line   (two_line),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (busy_flag) begin
            bf_run <= bf_run + 1;
        end else begin
            if (bf_run != 0) last_bf_len <= bf_run;
            bf_run <= 0;
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic bus_write(input logic r, input logic [3:0] nib);
        @(negedge clk);
        tb_oe = 1'b1; tb_dq = nib; rs = r; rw = 1'b0; en = 1'b1;
        repeat (4) @(negedge clk);
        en = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic write_byte(input logic r, input logic [7:0] b);
        bus_write(r, b[7:4]);
        bus_write(r, b[3:0]);
    endtask

    task automatic bus_read(input logic r, output logic [3:0] nib);
        @(negedge clk);
        tb_oe = 1'b0; rs = r; rw = 1'b1; en = 1'b1;
        repeat (4) @(negedge clk);
        nib = lcd_data;
        en = 1'b0;
        repeat (4) @(negedge clk);
        rw = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy_flag && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (busy_flag) begin
            checks++; failures++;
            $display("FAIL wait_idle: busy_flag still %0b after %0d cycles", busy_flag, n);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_cell(input logic [4:0] a, input logic [7:0] exp, input string nm);
        rd_addr = a;
        repeat (2) @(negedge clk);
        checks++;
        if (rd_char !== exp) begin
            failures++;
            $display("FAIL %s: rd_char[%02h] got %02h expected %02h", nm, a, rd_char, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ac, busy_flag, display_on, cursor_on, blink_on, four_bit, two_line, proto_err, rd_char} !== 22'd0) begin
            failures++;
            $display("FAIL reset_outputs: ac=%02h bf=%0b d=%0b 4b=%0b n=%0b pe=%0b rd=%02h expected all zero",
                     ac, busy_flag, display_on, four_bit, two_line, proto_err, rd_char);
        end
        rst_n = 1'b1;
        check_cell(5'h00, 8'h20, "reset_ddram0");
        check_cell(5'h1F, 8'h20, "reset_ddram31");
    endtask

    task automatic test_init_4bit();
        logic [3:0] seq [4];
        seq[0] = 4'h3; seq[1] = 4'h3; seq[2] = 4'h3; seq[3] = 4'h2;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (four_bit !== 1'b0) begin
                failures++;
                $display("FAIL init_mode_before_%0d: four_bit got %0b expected 0", i, four_bit);
            end
            bus_write(1'b0, seq[i]);
            wait_idle();
            checks++;
            if (last_bf_len != c_exec) begin
                failures++;
                $display("FAIL init_bf_len_%0d: busy cycles got %0d expected %0d", i, last_bf_len, c_exec);
            end
        end
        checks++;
        if (four_bit !== 1'b1) begin
            failures++;
            $display("FAIL init_four_bit: got %0b expected 1", four_bit);
        end
    endtask

    task automatic test_config_clear();
        write_byte(1'b0, 8'h28); wait_idle();
        write_byte(1'b0, 8'h0C); wait_idle();
        write_byte(1'b0, 8'h06); wait_idle();
        checks++;
        if ({two_line, display_on, cursor_on, blink_on} !== 4'b1100) begin
            failures++;
            $display("FAIL config_flags: n/d/c/b got %0b%0b%0b%0b expected 1100",
                     two_line, display_on, cursor_on, blink_on);
        end
        write_byte(1'b1, 8'h5A); wait_idle();
        check_cell(5'h00, 8'h5A, "config_data_before_clear");
        write_byte(1'b0, 8'h01); wait_idle();
        checks++;
        if (last_bf_len != c_clear) begin
            failures++;
            $display("FAIL clear_bf_len: busy cycles got %0d expected %0d", last_bf_len, c_clear);
        end
        checks++;
        if (ac !== 7'h00) begin
            failures++;
            $display("FAIL clear_ac: got %02h expected 00", ac);
        end
        for (int a = 0; a < 32; a++) begin
            check_cell(5'(a), 8'h20, "clear_cell");
        end
    endtask

    task automatic test_data_write();
        write_byte(1'b0, 8'h8E); wait_idle();
        write_byte(1'b1, 8'h48); wait_idle();
        write_byte(1'b1, 8'h69); wait_idle();
        checks++;
        if (ac !== 7'h10) begin
            failures++;
            $display("FAIL data_ac_after_row0: got %02h expected 10", ac);
        end
        write_byte(1'b0, 8'hC0); wait_idle();
        write_byte(1'b1, 8'h21); wait_idle();
        check_cell(5'h0E, 8'h48, "data_0E");
        check_cell(5'h0F, 8'h69, "data_0F");
        check_cell(5'h10, 8'h21, "data_row1_col0");
        check_cell(5'h0D, 8'h20, "data_0D_untouched");
        checks++;
        if (ac !== 7'h41) begin
            failures++;
            $display("FAIL data_ac_end: got %02h expected 41", ac);
        end
    endtask

    task automatic test_wrap();
        write_byte(1'b0, 8'hA7); wait_idle();
        write_byte(1'b1, 8'h58); wait_idle();
        checks++;
        if (ac !== 7'h40) begin
            failures++;
            $display("FAIL wrap_inc_27: ac got %02h expected 40", ac);
        end
        check_cell(5'h10, 8'h21, "wrap_row1_unchanged");
        check_cell(5'h0F, 8'h69, "wrap_row0_unchanged");
        write_byte(1'b0, 8'h80); wait_idle();
        write_byte(1'b0, 8'h04); wait_idle();
        write_byte(1'b1, 8'h59); wait_idle();
        checks++;
        if (ac !== 7'h67) begin
            failures++;
            $display("FAIL wrap_dec_00: ac got %02h expected 67", ac);
        end
        check_cell(5'h00, 8'h59, "wrap_dec_write");
        write_byte(1'b0, 8'h14); wait_idle();
        checks++;
        if (ac !== 7'h00) begin
            failures++;
            $display("FAIL shift_right_wrap: ac got %02h expected 00", ac);
        end
        write_byte(1'b0, 8'h06); wait_idle();
    endtask

    task automatic test_read();
        logic [3:0] n1, n2;
        write_byte(1'b0, 8'h8E); wait_idle();
        bus_read(1'b1, n1);
        bus_read(1'b1, n2);
        checks++;
        if ({n1, n2} !== 8'h48) begin
            failures++;
            $display("FAIL data_read: got %0h%0h expected 48", n1, n2);
        end
        checks++;
        if (ac !== 7'h0F) begin
            failures++;
            $display("FAIL data_read_ac_step: got %02h expected 0F", ac);
        end
        write_byte(1'b0, 8'h01);
        bus_read(1'b0, n1);
        bus_read(1'b0, n2);
        checks++;
        if ({n1, n2} !== 8'h80) begin
            failures++;
            $display("FAIL bf_read_clear: got %0h%0h expected 80", n1, n2);
        end
        wait_idle();
        write_byte(1'b0, 8'hC5); wait_idle();
        bus_read(1'b0, n1);
        bus_read(1'b0, n2);
        checks++;
        if ({n1, n2} !== 8'h45) begin
            failures++;
            $display("FAIL bf_read_idle: got %0h%0h expected 45", n1, n2);
        end
    endtask

    task automatic test_proto_err();
        checks++;
        if (proto_err !== 1'b0) begin
            failures++;
            $display("FAIL proto_err_clean: got %0b expected 0", proto_err);
        end
        write_byte(1'b0, 8'h08);
        write_byte(1'b0, 8'h0C);
        wait_idle();
        checks++;
        if ({proto_err, display_on} !== 2'b10) begin
            failures++;
            $display("FAIL proto_err_drop: pe/d got %0b%0b expected 10", proto_err, display_on);
        end
        write_byte(1'b0, 8'h01);
        repeat (5) @(negedge clk);
        checks++;
        if (busy_flag !== 1'b1) begin
            failures++;
            $display("FAIL mid_clear_busy: got %0b expected 1", busy_flag);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ac, busy_flag, display_on, four_bit, two_line, proto_err} !== 12'd0) begin
            failures++;
            $display("FAIL reset_mid_clear: ac=%02h bf=%0b d=%0b 4b=%0b n=%0b pe=%0b expected all zero",
                     ac, busy_flag, display_on, four_bit, two_line, proto_err);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus_write(1'b0, 4'h2);
        wait_idle();
        checks++;
        if (four_bit !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_8bit_fs: four_bit got %0b expected 1", four_bit);
        end
    endtask

    initial begin
        test_reset();
        test_init_4bit();
        test_config_clear();
        test_data_write();
        test_wrap();
        test_read();
        test_proto_err();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
